// File: rtl/mem_access_stage.sv
// Memory-access stage: registers execute outputs, runs data-bus loads/stores,
// aligns load data and hands a single-cycle result to write-back.
module mem_access_stage #(
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [13:0] control_word_ex,
  input  logic [31:0] ALU_result,
  input  logic [31:0] calculated_adr,
  input  logic [31:0] regfileb_ex,
  input  logic        flush,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_rf_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect,
  output logic [31:0] redirect_adr,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nx;

  logic [TO_W-1:0] to_cnt;

  logic       br_taken, rf_wb, mem_we, pc_src;
  logic [1:0] wb_src;
  logic [4:0] rd;
  logic [2:0] funct3;

  assign br_taken = control_word_ex[13];
  assign rf_wb    = control_word_ex[12];
  assign mem_we   = control_word_ex[11];
  assign wb_src   = control_word_ex[10:9];
  assign pc_src   = control_word_ex[8];
  assign rd       = control_word_ex[7:3];
  assign funct3   = control_word_ex[2:0];

  logic accept, is_load, is_mem, misal;
  logic done, tmo;

  assign mem_stall = (state == ACCESS);
  assign dmem_req  = (state == ACCESS);
  assign accept    = ex_valid & ~mem_stall & ~flush;
  assign is_load   = rf_wb & (wb_src == 2'b01) & ~mem_we;
  assign is_mem    = is_load | mem_we;
  assign misal     = funct3[1] ? |calculated_adr[1:0]
                               : (funct3[0] & calculated_adr[0]);

  assign done = (state == ACCESS) & dmem_ready;
  assign tmo  = (state == ACCESS) & ~dmem_ready
              & (to_cnt == TO_W'(BUS_TIMEOUT - 1));

  // State of the access in flight
  logic       a_load, a_rf_wb, a_kill;
  logic [4:0] a_rd;
  logic [2:0] a_f3;
  logic [1:0] a_off;

  logic [31:0] byte_sh, half_sh, ld_data;

  always_comb begin
    byte_sh = dmem_rdata >> {a_off, 3'b000};
    half_sh = dmem_rdata >> {a_off[1], 4'b0000};
    ld_data = dmem_rdata;
    unique case (a_f3)
      3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_data = {24'h0, byte_sh[7:0]};
      3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_data = {16'h0, half_sh[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  logic [31:0] st_data;
  logic [3:0]  st_strb;

  always_comb begin
    st_data = regfileb_ex;
    st_strb = 4'b1111;
    unique case (funct3)
      3'b000: begin
        st_data = {4{regfileb_ex[7:0]}};
        st_strb = 4'b0001 << calculated_adr[1:0];
      end
      3'b001: begin
        st_data = {2{regfileb_ex[15:0]}};
        st_strb = 4'b0011 << calculated_adr[1:0];
      end
      default: begin
        st_data = regfileb_ex;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && is_mem && !misal) state_nx = ACCESS;
      ACCESS:  if (done || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      a_load       <= 1'b0;
      a_rf_wb      <= 1'b0;
      a_kill       <= 1'b0;
      a_rd         <= '0;
      a_f3         <= '0;
      a_off        <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      wb_valid     <= 1'b0;
      wb_rf_we     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      redirect     <= 1'b0;
      redirect_adr <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_rf_we     <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (accept) begin
        redirect     <= br_taken | pc_src;
        redirect_adr <= calculated_adr;
        if (is_mem && misal) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd;
          wb_data      <= '0;
          misalign_err <= 1'b1;
        end else if (is_mem) begin
          to_cnt     <= '0;
          a_kill     <= 1'b0;
          a_load     <= is_load;
          a_rf_wb    <= rf_wb;
          a_rd       <= rd;
          a_f3       <= funct3;
          a_off      <= calculated_adr[1:0];
          dmem_we    <= mem_we;
          dmem_addr  <= {calculated_adr[31:2], 2'b00};
          dmem_wdata <= st_data;
          dmem_wstrb <= mem_we ? st_strb : 4'b0000;
        end else begin
          wb_valid <= 1'b1;
          wb_rf_we <= rf_wb;
          wb_rd    <= rd;
          wb_data  <= ALU_result;
        end
      end
      if (state == ACCESS) begin
        if (flush) a_kill <= 1'b1;
        if (!dmem_ready) to_cnt <= to_cnt + TO_W'(1);
        // A flushed access still finishes on the bus, but retires silently
        if (done) begin
          wb_valid <= ~a_kill & ~flush;
          wb_rf_we <= a_load & a_rf_wb & ~a_kill & ~flush;
          wb_rd    <= a_rd;
          wb_data  <= a_load ? ld_data : 32'h0;
        end else if (tmo) begin
          bus_err  <= 1'b1;
          wb_valid <= ~a_kill & ~flush;
          wb_rd    <= a_rd;
          wb_data  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU, loads, stores, misalign,
// bus timeout, flush during access and asynchronous reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [13:0] control_word_ex;
  logic [31:0] ALU_result;
  logic [31:0] calculated_adr;
  logic [31:0] regfileb_ex;
  logic        flush;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_adr;
  logic        misalign_err;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.BUS_TIMEOUT(4), .TO_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .control_word_ex (control_word_ex),
    .ALU_result      (ALU_result),
    .calculated_adr  (calculated_adr),
    .regfileb_ex     (regfileb_ex),
    .flush           (flush),
    .mem_stall       (mem_stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .wb_valid        (wb_valid),
    .wb_rf_we        (wb_rf_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .redirect        (redirect),
    .redirect_adr    (redirect_adr),
    .misalign_err    (misalign_err),
    .bus_err         (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one entry for a single cycle; returns at the following negedge
  task automatic issue(input logic [13:0] cw, input logic [31:0] alu,
                       input logic [31:0] adr, input logic [31:0] sd);
    ex_valid        = 1'b1;
    control_word_ex = cw;
    ALU_result      = alu;
    calculated_adr  = adr;
    regfileb_ex     = sd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3,
                           input logic [31:0] exp);
    issue({1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, f3}, 32'h0, 32'h103, 32'h0);
    chk({tag, "_stall1"}, 32'(mem_stall), 32'd1);
    chk({tag, "_addr1"}, dmem_addr, 32'h100);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    @(negedge clk);
    chk({tag, "_stall2"}, 32'(mem_stall), 32'd1);
    chk({tag, "_addr2"}, dmem_addr, 32'h100);
    @(negedge clk);
    chk({tag, "_stall3"}, 32'(mem_stall), 32'd1);
    chk({tag, "_addr3"}, dmem_addr, 32'h100);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h80AA_BBCC;
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    chk({tag, "_stall_end"}, 32'(mem_stall), 32'd0);
    chk({tag, "_req_end"}, 32'(dmem_req), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_wbwe"}, 32'(wb_rf_we), 32'd1);
    chk({tag, "_rd"}, 32'(wb_rd), 32'd7);
    chk({tag, "_data"}, wb_data, exp);
  endtask

  initial begin
    rst_n           = 1'b0;
    ex_valid        = 1'b0;
    control_word_ex = '0;
    ALU_result      = '0;
    calculated_adr  = '0;
    regfileb_ex     = '0;
    flush           = 1'b0;
    dmem_ready      = 1'b0;
    dmem_rdata      = '0;

    #12;
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_errs", {30'h0, misalign_err, bus_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU-only entry
    issue({1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 3'b000},
          32'h1234, 32'h0, 32'h0);
    chk("alu_wbv", 32'(wb_valid), 32'd1);
    chk("alu_wbwe", 32'(wb_rf_we), 32'd1);
    chk("alu_rd", 32'(wb_rd), 32'd3);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_stall", 32'(mem_stall), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("alu_wbv_drop", 32'(wb_valid), 32'd0);

    load_case("lb", 3'b000, 32'hFFFF_FF80);
    load_case("lbu", 3'b100, 32'h0000_0080);
    @(negedge clk);

    // Store halfword into upper lanes
    issue({1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 3'b001},
          32'h0, 32'h102, 32'h0000_BEEF);
    chk("sh_req", 32'(dmem_req), 32'd1);
    chk("sh_we", 32'(dmem_we), 32'd1);
    chk("sh_addr", dmem_addr, 32'h100);
    chk("sh_strb", 32'(dmem_wstrb), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("sh_wbv", 32'(wb_valid), 32'd1);
    chk("sh_wbwe", 32'(wb_rf_we), 32'd0);
    chk("sh_stall", 32'(mem_stall), 32'd0);

    // Misaligned word load
    issue({1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 3'b010},
          32'h0, 32'h101, 32'h0);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_wbv", 32'(wb_valid), 32'd1);
    chk("mis_wbwe", 32'(wb_rf_we), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    chk("mis_err_drop", 32'(misalign_err), 32'd0);

    // Taken branch redirect
    issue({1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 3'b000},
          32'h0, 32'h400, 32'h0);
    chk("br_redir", 32'(redirect), 32'd1);
    chk("br_adr", redirect_adr, 32'h400);
    chk("br_wbwe", 32'(wb_rf_we), 32'd0);
    @(negedge clk);
    chk("br_redir_drop", 32'(redirect), 32'd0);

    // Bus timeout: ready never arrives
    issue({1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd5, 3'b010},
          32'h0, 32'h200, 32'h0);
    chk("to_req", 32'(dmem_req), 32'd1);
    repeat (3) @(negedge clk);
    chk("to_req_4th", 32'(dmem_req), 32'd1);
    chk("to_berr_early", 32'(bus_err), 32'd0);
    @(negedge clk);
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_stall", 32'(mem_stall), 32'd0);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_wbv", 32'(wb_valid), 32'd1);
    chk("to_wbwe", 32'(wb_rf_we), 32'd0);
    @(negedge clk);
    chk("to_berr_drop", 32'(bus_err), 32'd0);

    // Flush mid-access: bus completes, write-back suppressed
    issue({1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd4, 3'b010},
          32'h0, 32'h300, 32'h0);
    chk("fl_req", 32'(dmem_req), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_req_hold", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h55;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("fl_wbv", 32'(wb_valid), 32'd0);
    chk("fl_wbwe", 32'(wb_rf_we), 32'd0);
    chk("fl_stall", 32'(mem_stall), 32'd0);

    // Asynchronous reset during an access
    issue({1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd6, 3'b010},
          32'h0, 32'h500, 32'h0);
    chk("ar_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(dmem_req), 32'd0);
    chk("ar_stall", 32'(mem_stall), 32'd0);
    chk("ar_addr", dmem_addr, 32'h0);
    chk("ar_redir_adr", redirect_adr, 32'h0);
    chk("ar_wbv", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after reset
    issue({1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd12, 3'b000},
          32'hCAFE_F00D, 32'h0, 32'h0);
    chk("rec_wbv", 32'(wb_valid), 32'd1);
    chk("rec_rd", 32'(wb_rd), 32'd12);
    chk("rec_data", wb_data, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
